// File: rtl/conv_pkg.sv
// Shared types and defaults for the sliding-window convolution controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package conv_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_IMAGE_WIDTH  = 28;
    localparam int DEF_KERNEL_WIDTH = 5;

    // Bits needed to hold 0..width-1; never narrower than one bit
    function automatic int cw_of(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/conv_window_ctrl_valid_delay.sv
// Fixed-depth 2-bit delay line carrying {complete, last} window flags.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every clock, flush clears all stages synchronously.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [DEPTH-1:0][1:0] pipe;

    // Shift the flags one stage per clock; flush drops everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the convolution datapath: accepts raster pixels, tracks row/col, flags complete windows.
// Latency: win_valid/win_last trail the accepting shift_en by PIPE_LAT cycles; done PIPE_LAT+1 after the last pixel.
// Backpressure: in_ready only in RUN; the shift chains cannot stall, so in_valid low in RUN aborts the frame (err).
// Optional build macro CONV_STRIDE2_EN: emit only every second window in both directions.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter  int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter  int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
    parameter  int PIPE_LAT     = 2,
    localparam int CW           = cw_of(IMAGE_WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          win_valid,
    output logic          win_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int DW = cw_of(PIPE_LAT);

    localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] K_M1     = CW'(KERNEL_WIDTH - 1);
`ifdef CONV_STRIDE2_EN
    // Final emitted window sits on the last even offset from the first window
    localparam int LAST_WIN_I = (KERNEL_WIDTH - 1) + 2 * ((IMAGE_WIDTH - KERNEL_WIDTH) / 2);
`else
    localparam int LAST_WIN_I = IMAGE_WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST_WIN = CW'(LAST_WIN_I);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [DW-1:0] drain_q;
    logic          done_nxt;
    logic          err_nxt;
    logic          run_entry;
    logic          underrun;
    logic          win_cmp;
    logic          win_lst;
    logic [1:0]    dly_out;

    // Next state, handshake and completion pulses
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        run_entry = 1'b0;
        underrun  = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                // err high means the frame just aborted; a start here is dropped
                if (start && !err) begin
                    state_nxt = RUN;
                    run_entry = 1'b1;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (!in_valid) begin
                    underrun  = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (row_q == LAST_IDX && col_q == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(PIPE_LAT - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign shift_en = in_valid & in_ready;

    // State register and registered done/err pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Count cycles spent in DRAIN so the MAC pipe empties before done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_q <= '0;
        end else if (state != DRAIN) begin
            drain_q <= '0;
        end else begin
            drain_q <= drain_q + DW'(1);
        end
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (run_entry || underrun) begin
            row_q <= '0;
            col_q <= '0;
        end else if (shift_en) begin
            if (col_q == LAST_IDX) begin
                col_q <= '0;
                row_q <= row_q + CW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    assign row = row_q;
    assign col = col_q;

`ifdef CONV_STRIDE2_EN
    logic [CW-1:0] row_off;
    logic [CW-1:0] col_off;
    assign row_off = row_q - K_M1;
    assign col_off = col_q - K_M1;
`endif

    // Window is complete once the kernel fully overlaps the image
    always_comb begin
        win_cmp = shift_en && (row_q >= K_M1) && (col_q >= K_M1);
`ifdef CONV_STRIDE2_EN
        win_cmp = win_cmp && !row_off[0] && !col_off[0];
`endif
        win_lst = win_cmp && (row_q == LAST_WIN) && (col_q == LAST_WIN);
    end

    valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .flush (underrun),
        .din   ({win_cmp, win_lst}),
        .dout  (dly_out)
    );

    assign win_valid = dly_out[1];
    assign win_last  = dly_out[0];

    // done is emitted from IDLE, so it is folded in to keep busy high through it
    assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench: handshake vector table, then full frames scored against a pixel-index model.
// Latency: checks win_valid at acceptance + PIPE_LAT, done at last pixel + PIPE_LAT + 1.
// Backpressure: exercises underrun abort, ignored start pulses and mid-frame reset.
module tb_conv_window_ctrl;

    localparam int W        = 28;
    localparam int K        = 5;
    localparam int PIPE_LAT = 2;
    localparam int CW       = $clog2(W);
    localparam int NPIX     = W * W;
`ifdef CONV_STRIDE2_EN
    localparam int WIN_EXP  = ((W - K + 2) / 2) * ((W - K + 2) / 2);
`else
    localparam int WIN_EXP  = (W - K + 1) * (W - K + 1);
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          win_valid;
    logic          win_last;
    logic          busy;
    logic          done;
    logic          err;

    conv_window_ctrl #(
        .IMAGE_WIDTH  (W),
        .KERNEL_WIDTH (K),
        .PIPE_LAT     (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .row       (row),
        .col       (col),
        .win_valid (win_valid),
        .win_last  (win_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, indexed by raster pixel number
    function automatic bit is_win(input int k);
        int r;
        int c;
        bit ok;
        r  = k / W;
        c  = k % W;
        ok = (r >= K - 1) && (c >= K - 1);
`ifdef CONV_STRIDE2_EN
        ok = ok && (((r - (K - 1)) % 2) == 0) && (((c - (K - 1)) % 2) == 0);
`endif
        return ok;
    endfunction

    function automatic int find_last_k();
        int lk;
        lk = -1;
        for (int k = 0; k < NPIX; k++) if (is_win(k)) lk = k;
        return lk;
    endfunction

    int last_k;

    // Scoreboard of expected window outputs
    typedef struct {
        int due;
        bit last;
    } exp_t;
    exp_t sb[$];

    int n_win         = 0;
    int n_done        = 0;
    int n_shift       = 0;
    int first_win_cyc = -1;
    int last_win_cyc  = -1;
    int done_cyc      = -1;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("win_missing_due", 32'(cyc), 32'(e.due));
            end
            if (win_valid) begin
                n_win++;
                if (first_win_cyc < 0) first_win_cyc = cyc;
                if (win_last) last_win_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("win_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("win_cycle", 32'(cyc), 32'(e.due));
                    chk("win_last_flag", 32'(win_last), 32'(e.last));
                end
            end else if (win_last) begin
                chk("win_last_alone", 32'(win_last), 32'(0));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (shift_en) n_shift++;
        end
    end

    // Drive one frame; optionally drop in_valid, re-pulse start, or reset at pixel index
    task automatic run_frame(input int drop_k, input int restart_k, input int reset_k,
                             output int t0);
        int  tl;
        bit  stop;
        bit  seen;
        tl   = 0;
        stop = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; t0 = cyc;
        for (int k = 0; k < NPIX && !stop; k++) begin
            @(posedge clk); #1;
            start    = (k == restart_k);
            in_valid = (k != drop_k);
            if (k == reset_k) begin
                reset = 1'b1; #1;
                chk("rst_in_ready", 32'(in_ready), 32'(0));
                chk("rst_shift_en", 32'(shift_en), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_win_valid", 32'(win_valid), 32'(0));
                chk("rst_rowcol", 32'({row, col}), 32'(0));
                sb.delete();
                @(posedge clk); #1;
                reset = 1'b0; start = 1'b0; in_valid = 1'b0;
                stop = 1'b1;
            end else begin
                #1;
                if (k == drop_k) begin
                    chk("drop_shift_en", 32'(shift_en), 32'(0));
                    while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
                    @(posedge clk); #1;
                    start = 1'b0; in_valid = 1'b0; #1;
                    chk("drop_err", 32'(err), 32'(1));
                    chk("drop_in_ready", 32'(in_ready), 32'(0));
                    chk("drop_busy", 32'(busy), 32'(0));
                    stop = 1'b1;
                end else begin
                    chk("pix_shift_en", 32'(shift_en), 32'(1));
                    chk("pix_row", 32'(row), 32'(k / W));
                    chk("pix_col", 32'(col), 32'(k % W));
                    if (is_win(k)) sb.push_back('{due: cyc + PIPE_LAT, last: (k == last_k)});
                    tl = cyc;
                end
            end
        end
        start = 1'b0;
        if (!stop) begin
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk); #1;
                in_valid = 1'b0; #1;
                if (done) begin
                    seen = 1'b1;
                    chk("done_latency", 32'(cyc - tl), 32'(PIPE_LAT + 1));
                    chk("busy_in_done", 32'(busy), 32'(1));
                end
            end
            chk("done_seen", 32'(seen), 32'(1));
            @(posedge clk); #2;
            chk("busy_after_done", 32'(busy), 32'(0));
            chk("done_one_cycle", 32'(done), 32'(0));
        end
    endtask

    // Handshake vector table: one record per cycle
    typedef struct {
        logic rst, st, iv;
        logic rdy, sh, bsy, dn, er;
        int   r, c;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic rst, st, iv, rdy, sh, bsy, dn, er, input int r, c);
        vecs.push_back('{rst:rst, st:st, iv:iv, rdy:rdy, sh:sh, bsy:bsy, dn:dn, er:er, r:r, c:c});
    endtask

    initial begin
        int t0, n0, d0, s0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        last_k = find_last_k();

        //      rst st iv  rdy sh bsy dn er  row col
        for (int i = 0; i < 10; i++) add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 1, 0, 0, 0, 0, 0, -1, -1);
        add_vec(0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
        add_vec(0, 1, 1, 1, 1, 1, 0, 0, 0, 2);
        add_vec(0, 0, 1, 1, 1, 1, 0, 0, 0, 3);
        add_vec(0, 0, 0, 1, 0, 1, 0, 0, -1, -1);
        add_vec(0, 1, 1, 0, 0, 0, 0, 1, -1, -1);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0, -1, -1);
        add_vec(0, 1, 0, 0, 0, 0, 0, 0, -1, -1);
        add_vec(0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 1, 0, 1, 0, 0, -1, -1);
        add_vec(0, 0, 0, 0, 0, 0, 0, 1, -1, -1);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, -1, -1);

        repeat (3) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset = vecs[i].rst; start = vecs[i].st; in_valid = vecs[i].iv; #1;
            chk("tbl_in_ready", 32'(in_ready), 32'(vecs[i].rdy));
            chk("tbl_shift_en", 32'(shift_en), 32'(vecs[i].sh));
            chk("tbl_busy", 32'(busy), 32'(vecs[i].bsy));
            chk("tbl_done", 32'(done), 32'(vecs[i].dn));
            chk("tbl_err", 32'(err), 32'(vecs[i].er));
            chk("tbl_win_valid", 32'(win_valid), 32'(0));
            if (vecs[i].r >= 0) begin
                chk("tbl_row", 32'(row), 32'(vecs[i].r));
                chk("tbl_col", 32'(col), 32'(vecs[i].c));
            end
        end
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;

        // Full frame, in_valid held high
        n0 = n_win; d0 = n_done; s0 = n_shift; first_win_cyc = -1; last_win_cyc = -1;
        run_frame(-1, -1, -1, t0);
        chk("A_win_count", 32'(n_win - n0), 32'(WIN_EXP));
        chk("A_done_count", 32'(n_done - d0), 32'(1));
        chk("A_shift_count", 32'(n_shift - s0), 32'(NPIX));
        chk("A_first_win", 32'(first_win_cyc - t0), 32'(119));
`ifndef CONV_STRIDE2_EN
        chk("A_last_win", 32'(last_win_cyc - t0), 32'(786));
        chk("A_done_cycle", 32'(done_cyc - t0), 32'(787));
`endif

        // start re-pulsed mid-frame must not disturb it
        n0 = n_win; d0 = n_done;
        run_frame(-1, 200, -1, t0);
        chk("B_win_count", 32'(n_win - n0), 32'(WIN_EXP));
        chk("B_done_count", 32'(n_done - d0), 32'(1));

        // Underrun at pixel 300: abort, no further windows, no done
        d0 = n_done;
        run_frame(300, -1, -1, t0);
        n0 = n_win;
        repeat (60) @(posedge clk);
        #2;
        chk("C_no_win_after_err", 32'(n_win - n0), 32'(0));
        chk("C_no_done", 32'(n_done - d0), 32'(0));
        chk("C_idle_ready", 32'(in_ready), 32'(0));
        chk("C_sb_drained", 32'(sb.size()), 32'(0));

        // Reset mid-frame at pixel 500, then a fresh frame
        d0 = n_done;
        run_frame(-1, -1, 500, t0);
        repeat (5) @(posedge clk);
        chk("D_no_done", 32'(n_done - d0), 32'(0));
        n0 = n_win; d0 = n_done;
        run_frame(-1, -1, -1, t0);
        chk("E_win_count", 32'(n_win - n0), 32'(WIN_EXP));
        chk("E_done_count", 32'(n_done - d0), 32'(1));
        chk("E_sb_empty", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
